// File: rtl/free_list_manager.sv
// Physical-register free list: circular FIFO of free rename tags, prefilled with NUM_ARCH..NUM_PHYS-1.
// Optional duplicate-release detection via a free bitmap is enabled by defining FREE_LIST_CHECK_EN.
module free_list_manager #(
  parameter int NUM_PHYS = 64,
  parameter int NUM_ARCH = 32,
  localparam int DEPTH = NUM_PHYS - NUM_ARCH,
  localparam int TAG_W = $clog2(NUM_PHYS),
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int PTR_W = IDX_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             alloc_req,
  output logic             alloc_gnt,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             release_valid,
  input  logic [TAG_W-1:0] release_tag,
  output logic [CNT_W-1:0] free_count,
  output logic             empty,
  output logic             overflow_err,
  output logic             double_free_err
);

  logic [TAG_W-1:0] fifo_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovfErr_q, ovfErr_d;
  logic             full;
  logic             relCandidate;
  logic             relAccept;
  logic             alreadyFree;

  // Pointers carry a wrap bit above the index so equal indices distinguish full from empty.
  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
    if (p[IDX_W-1:0] == IDX_W'(DEPTH - 1)) begin
      ptrInc = {~p[PTR_W-1], {IDX_W{1'b0}}};
    end else begin
      ptrInc = p + PTR_W'(1);
    end
  endfunction

  assign full  = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) && (head_q[PTR_W-1] != tail_q[PTR_W-1]);
  assign empty = (head_q == tail_q);

  assign alloc_tag  = fifo_q[head_q[IDX_W-1:0]];
  assign alloc_gnt  = alloc_req & ~empty & ~flush & rst_n;
  assign free_count = count_q;

  assign relCandidate = release_valid & ~flush & (release_tag != '0);
  assign relAccept    = relCandidate & ~full & ~alreadyFree;

  assign overflow_err = ovfErr_q;

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    ovfErr_d = relCandidate & full;
    if (flush) begin
      head_d  = '0;
      tail_d  = {1'b1, {IDX_W{1'b0}}};
      count_d = CNT_W'(DEPTH);
    end else begin
      if (alloc_gnt) begin
        head_d = ptrInc(head_q);
      end
      if (relAccept) begin
        tail_d = ptrInc(tail_q);
      end
      case ({relAccept, alloc_gnt})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q   <= '0;
      tail_q   <= {1'b1, {IDX_W{1'b0}}};
      count_q  <= CNT_W'(DEPTH);
      ovfErr_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      ovfErr_q <= ovfErr_d;
    end
  end

  // Storage is refilled with the post-reset tag sequence on both reset and flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= TAG_W'(NUM_ARCH + i);
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= TAG_W'(NUM_ARCH + i);
      end
    end else if (relAccept) begin
      fifo_q[tail_q[IDX_W-1:0]] <= release_tag;
    end
  end

`ifdef FREE_LIST_CHECK_EN
  localparam logic [NUM_PHYS-1:0] RESET_MAP = {NUM_PHYS{1'b1}} << NUM_ARCH;

  logic [NUM_PHYS-1:0] freeMap_q, freeMap_d;
  logic                dblErr_q, dblErr_d;

  assign alreadyFree     = freeMap_q[release_tag];
  assign double_free_err = dblErr_q;

  always_comb begin
    freeMap_d = freeMap_q;
    dblErr_d  = relCandidate & ~full & alreadyFree;
    if (flush) begin
      freeMap_d = RESET_MAP;
    end else begin
      if (alloc_gnt) begin
        freeMap_d[alloc_tag] = 1'b0;
      end
      if (relAccept) begin
        freeMap_d[release_tag] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freeMap_q <= RESET_MAP;
      dblErr_q  <= 1'b0;
    end else begin
      freeMap_q <= freeMap_d;
      dblErr_q  <= dblErr_d;
    end
  end
`else
  assign alreadyFree     = 1'b0;
  assign double_free_err = 1'b0;
`endif

endmodule
